// File: rtl/data_mem_controller_if.sv
// data_mem_controller_if: request, memory and response
// bundles of the load/store stage.
interface data_mem_controller_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int TID_WIDTH  = 2,
   parameter int FIFO_DEPTH = 4
);
   // request from the core
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic [DATA_WIDTH-1:0]     req_wdata;
   logic [TID_WIDTH-1:0]      req_thread;
   // external data memory
   logic                      mem_valid;
   logic                      mem_write;
   logic [ADDR_WIDTH-1:0]     mem_addr;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic                      mem_ack;
   logic [DATA_WIDTH-1:0]     mem_rdata;
   // response to the core
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [TID_WIDTH-1:0]      rsp_thread;
   logic                      rsp_write;
   logic [DATA_WIDTH-1:0]     rsp_data;
   logic                      rsp_error;
   logic [$clog2(FIFO_DEPTH):0] pending;

   // controller side
   modport slave (
      input  req_valid, req_write, req_addr,
      input  req_wdata, req_thread,
      output req_ready,
      output mem_valid, mem_write, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output rsp_valid, rsp_thread, rsp_write,
      output rsp_data, rsp_error, pending,
      input  rsp_ready
   );

   // core and memory side
   modport master (
      output req_valid, req_write, req_addr,
      output req_wdata, req_thread,
      input  req_ready,
      input  mem_valid, mem_write, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  rsp_valid, rsp_thread, rsp_write,
      input  rsp_data, rsp_error, pending,
      output rsp_ready
   );
endinterface

// File: rtl/data_mem_controller.sv
// data_mem_controller: queued LDR/STR stage, one memory
// access in flight, tagged responses, ack watchdog.
module data_mem_controller #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 8,
   parameter int TID_WIDTH      = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   data_mem_controller_if.slave bus_io
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int PEND_W = PTR_W + 1;
   localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [TID_WIDTH-1:0]  tid;
   } req_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   req_t                  fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PEND_W-1:0]     cnt_q, cnt_d;
   req_t                  cur_q, cur_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [WD_W-1:0]       wdog_q, wdog_d;
   logic [WD_W-1:0]       wdog_inc;
   logic                  req_ready;
   logic                  push;
   logic                  pop;
   req_t                  head;

   // ready depends only on the registered occupancy
   assign req_ready = (cnt_q != PEND_W'(FIFO_DEPTH));
   assign push      = bus_io.req_valid && req_ready;
   assign pop       = (state_q == IDLE) &&
                      (cnt_q != '0);
   assign head      = fifo_q[rd_ptr_q];
   assign wdog_inc  = wdog_q + WD_W'(1);

   // queue occupancy and pointer updates
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + PEND_W'(1);
         2'b01:   cnt_d = cnt_q - PEND_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // queue storage, written on accepted requests
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= '{
            write: bus_io.req_write,
            addr:  bus_io.req_addr,
            wdata: bus_io.req_wdata,
            tid:   bus_io.req_thread
         };
      end
   end

   // access sequencing: pop, wait ack or timeout, respond
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wdog_d  = wdog_q;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               cur_d   = head;
               wdog_d  = '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (bus_io.mem_ack) begin
               rdata_d = cur_q.write ? '0
                                     : bus_io.mem_rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (wdog_inc ==
                         WD_W'(TIMEOUT_CYCLES)) begin
               wdog_d  = wdog_inc;
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wdog_d  = wdog_inc;
            end
         end
         RESP: begin
            if (bus_io.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state, pointers and working registers
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         cur_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         wdog_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         cur_q    <= cur_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         wdog_q   <= wdog_d;
      end
   end

   // outputs come straight from registered state
   always_comb begin
      bus_io.req_ready  = req_ready;
      bus_io.mem_valid  = (state_q == ACCESS);
      bus_io.mem_write  = cur_q.write;
      bus_io.mem_addr   = cur_q.addr;
      bus_io.mem_wdata  = cur_q.wdata;
      bus_io.rsp_valid  = (state_q == RESP);
      bus_io.rsp_thread = cur_q.tid;
      bus_io.rsp_write  = cur_q.write;
      bus_io.rsp_data   = rdata_q;
      bus_io.rsp_error  = err_q;
      bus_io.pending    = cnt_q;
   end
endmodule
